// File: rtl/taillight_pkg.sv
// Shared types and helpers for the sequential taillight controller.
package taillight_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'd0,
    MODE_LEFT  = 2'd1,
    MODE_RIGHT = 2'd2,
    MODE_HAZ   = 2'd3
  } mode_t;

  localparam int MAX_LAMPS = 8;

  // Thermometer code: the low `step` bits set, clipped to `lamps` bits.
  function automatic logic [MAX_LAMPS-1:0] therm(input logic [3:0] step, input int lamps);
    logic [MAX_LAMPS-1:0] code;
    code = '0;
    for (int i = 0; i < MAX_LAMPS; i++) begin
      code[i] = (i < int'(step)) && (i < lamps);
    end
    return code;
  endfunction

endpackage

// File: rtl/taillight_seq_tick_gen.sv
// Animation prescaler: one-cycle tick every DIV clocks, restartable by clr.
module tick_gen #(
  parameter int DIV = 12500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          tick_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // tick is registered so it is high exactly while the count sits at LAST
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == LAST);
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/taillight_seq.sv
// Parametrised taillight controller: turn sweep, hazard flash and brake overlay
// driven from asynchronous switches through per-input synchronisers.
module taillight_seq
  import taillight_pkg::*;
#(
  parameter int LAMPS       = 3,
  parameter int DIV         = 12500000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             left,
  input  logic             right,
  input  logic             hazard,
  input  logic             brake,
  output logic [LAMPS-1:0] tl,
  output logic [LAMPS-1:0] tr,
  output logic [1:0]       mode,
  output logic             tick
);

  logic [3:0]                  raw_s;
  logic [3:0]                  sync_s;
  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic                        left_s, right_s, hazard_s, brake_s;

  mode_t                 mode_q, mode_d;
  logic [3:0]            step_q, step_d;
  logic                  phase_q, phase_d;
  logic                  mode_chg_s;
  logic                  tick_s;
  logic [LAMPS-1:0]      tl_q, tl_d, tr_q, tr_d;
  logic [LAMPS-1:0]      ovl_s, therm_s;
  logic [MAX_LAMPS-1:0]  therm_full_s;

  assign raw_s = {brake, hazard, right, left};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_s};
    end
  end

  assign sync_s   = sync_q[SYNC_STAGES-1];
  assign left_s   = sync_s[0];
  assign right_s  = sync_s[1];
  assign hazard_s = sync_s[2];
  assign brake_s  = sync_s[3];

  always_comb begin
    mode_d = MODE_IDLE;
    if (hazard_s || (left_s && right_s)) begin
      mode_d = MODE_HAZ;
    end else if (left_s) begin
      mode_d = MODE_LEFT;
    end else if (right_s) begin
      mode_d = MODE_RIGHT;
    end else begin
      mode_d = MODE_IDLE;
    end
  end

  assign mode_chg_s = (mode_d != mode_q);

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (mode_chg_s),
    .tick  (tick_s)
  );

  // Entering HAZ starts with the phase on so the flash is visible immediately
  always_comb begin
    step_d  = step_q;
    phase_d = phase_q;
    if (mode_chg_s) begin
      step_d  = 4'd0;
      phase_d = (mode_d == MODE_HAZ);
    end else if (tick_s) begin
      case (mode_q)
        MODE_LEFT, MODE_RIGHT: begin
          step_d = (step_q == 4'(LAMPS)) ? 4'd0 : step_q + 4'd1;
        end
        MODE_HAZ: begin
          phase_d = ~phase_q;
        end
        default: begin
          step_d  = 4'd0;
          phase_d = 1'b0;
        end
      endcase
    end else begin
      step_d  = step_q;
      phase_d = phase_q;
    end
  end

  assign therm_full_s = therm(step_d, LAMPS);
  assign therm_s      = therm_full_s[LAMPS-1:0];
  assign ovl_s        = brake_s ? {LAMPS{1'b1}} : '0;

  always_comb begin
    tl_d = '0;
    tr_d = '0;
    case (mode_d)
      MODE_LEFT: begin
        tl_d = therm_s;
        tr_d = ovl_s;
      end
      MODE_RIGHT: begin
        tl_d = ovl_s;
        tr_d = therm_s;
      end
      MODE_HAZ: begin
        tl_d = {LAMPS{phase_d}};
        tr_d = {LAMPS{phase_d}};
      end
      default: begin
        tl_d = ovl_s;
        tr_d = ovl_s;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_IDLE;
      step_q  <= 4'd0;
      phase_q <= 1'b0;
      tl_q    <= '0;
      tr_q    <= '0;
    end else begin
      mode_q  <= mode_d;
      step_q  <= step_d;
      phase_q <= phase_d;
      tl_q    <= tl_d;
      tr_q    <= tr_d;
    end
  end

  assign tl   = tl_q;
  assign tr   = tr_q;
  assign mode = mode_q;
  assign tick = tick_s;

endmodule

// File: doc/taillight_seq.md
Name: taillight_seq

Overview:
- Parametrised sequential taillight controller, the successor to the fixed 3-lamp turn/brake/error block.
- Drives LAMPS lamps per side with a thermometer-style turn sweep, a hazard flash, and brake overlay.
- An internal prescaler paces the animation, so the board clock can feed the block directly.
- Sits between the board switches and the LED outputs; switch inputs are asynchronous and synchronised inside the block.

Parameters:
- LAMPS, 3, lamps per side (1..8); bit 0 is the lamp nearest the vehicle centre.
- DIV, 12500000, clk cycles per animation tick (>=1); 4 Hz at 50 MHz.
- SYNC_STAGES, 2, flops per input synchroniser (>=2).

Ports:
- clk, in, 1, system clock; all state is updated on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- left, in, 1, left turn request (async switch).
- right, in, 1, right turn request (async switch).
- hazard, in, 1, hazard/error request (async switch).
- brake, in, 1, brake pedal (async switch).
- tl, out, LAMPS, left lamps, registered, active-high.
- tr, out, LAMPS, right lamps, registered, active-high.
- mode, out, 2, current mode: 0=IDLE, 1=LEFT, 2=RIGHT, 3=HAZ.
- tick, out, 1, one-cycle pulse on each animation tick (debug/LED).

Behaviour:
- Reset (async, rst_n=0):
  - tl=0, tr=0, mode=IDLE, tick=0.
  - Step counter=0, hazard phase=0, prescaler=0, synchronisers=0.
  - Outputs clear immediately, not at the next edge.
- Input path:
  - Each input passes SYNC_STAGES flops before use.
  - An input stable before edge n is reflected in mode/tl/tr after edge n+SYNC_STAGES.
- Mode select, evaluated every cycle from synchronised inputs; priority high to low:
  - hazard=1, or left=1 and right=1 -> HAZ.
  - left=1 -> LEFT.
  - right=1 -> RIGHT.
  - otherwise -> IDLE.
- On any mode change:
  - Step counter clears to 0 and the prescaler restarts at 0.
  - The first tick in the new mode occurs DIV cycles after the change.
  - Hazard phase is set to 1, so HAZ gives visible response at once.
- Prescaler:
  - Counts 0..DIV-1; tick=1 for the one cycle when count==DIV-1, then the count wraps to 0.
  - DIV=1 gives tick every cycle.
  - Counter width is clog2(DIV), minimum 1.
- LEFT:
  - Step counter counts 0..LAMPS, advancing on each tick, and wraps LAMPS->0.
  - tl = thermometer(step): the low `step` bits are set. For LAMPS=3 the sequence is 000, 001, 011, 111, 000, ...
  - tr = all ones if brake=1, else 0.
- RIGHT: mirror of LEFT, with tr animating and tl carrying the brake overlay.
- HAZ:
  - Hazard phase toggles on each tick.
  - tl = tr = all ones when phase=1, else 0.
  - brake is ignored in HAZ.
- IDLE:
  - tl = tr = all ones if brake=1, else 0.
  - Step counter and phase hold at 0.
- Brake change within LEFT/RIGHT:
  - Affects only the non-turning side, after the synchroniser latency.
  - Does not reset the sweep or the prescaler.
- Reset mid-sweep: outputs clear asynchronously. After release, the block resumes from IDLE and re-evaluates inputs through the synchroniser.
- All outputs are registered; there is no combinational input-to-output path.

Decomposition:
- Package taillight_pkg holds:
  - the mode_t enum (IDLE, LEFT, RIGHT, HAZ) and its 2-bit encoding;
  - a function therm(step, LAMPS) returning a LAMPS-bit thermometer code.
- Sub-module tick_gen (parameter DIV; ports clk, rst_n, clr, tick) implements the prescaler with a synchronous clear on mode change.
- Synchronisers, mode FSM, step counter and output registers live in taillight_seq.

Test Plan:
- Reset, then left=1 with LAMPS=3, DIV=4:
  - mode=1 two cycles after the input settles, tl=000.
  - tl then steps 001, 011, 111, 000 at 4-cycle intervals; tr=000 throughout.
- right=1 with brake=1 (LAMPS=4, DIV=2): tr sweeps 0000, 0001, 0011, 0111, 1111, 0000 every 2 cycles; tl=1111 steady.
- hazard=1 while right is sweeping at step 2:
  - mode=3 and tl=tr=111 on the transition edge.
  - Both sides toggle to 000 after 4 cycles, then to 111 after 4 more; brake toggling has no effect.
- left=1 and right=1 together: mode=3 (HAZ) flash, same as the hazard scenario.
- Brake only in IDLE: tl=tr=111 two cycles after brake rises; both clear two cycles after brake falls.
- Assert rst_n=0 mid-cycle during a LEFT sweep at tl=011:
  - tl/tr/mode go to 0 without a clock edge.
  - After release with left held, the sweep restarts from 000.
